id_decode_queue: RTL and testbench
==================================

// Module: id_decode_queue
// PURPOSE
//  Parametrised multi-way decode stage with a registered decode queue between the instruction buffer and dispatch.
//  Accepts up to WAYS instructions per cycle and decodes each one (RV32I opcode class) at enqueue.
//  Stores entries in order in a DEPTH-entry circular queue; dispatch drains 0..WAYS oldest entries per cycle.
//  Decouples fetch-side bursts from dispatch stalls; flush supports branch-mispredict recovery.
// PARAMETERS
//  WAYS   2   lanes per cycle, in and out (>=1)
//  DEPTH  4   queue entries (>=WAYS; need not be a power of two)
// PORTS
//  clock       in   1           rising-edge clock
//  reset       in   1           asynchronous, active-low reset
//  flush       in   1           discard all queued entries and this cycle's inputs
//  in_valid    in   WAYS        lane valid; only the leading run of ones from lane 0 is used
//  in_inst     in   WAYS*32     instruction per lane, lane i at [32i+:32]
//  in_pc       in   WAYS*32     PC per lane
//  in_ready    out  1           queue can take WAYS entries this cycle
//  out_valid   out  WAYS        thermometer code: lanes 0..min(count,WAYS)-1 valid, lane 0 oldest
//  out_inst    out  WAYS*32     queued instruction per lane
//  out_pc      out  WAYS*32     queued PC per lane
//  out_npc     out  WAYS*32     out_pc+4 (mod 2^32)
//  out_dec     out  WAYS*12     decode word per lane (see below)
//  out_accept  in   $clog2(WAYS+1)  lanes dispatch consumes this cycle
//  count       out  $clog2(DEPTH+1) current occupancy
// BEHAVIOUR
//  Reset (reset low, async): head=tail=count=0. out_valid=0, in_ready=1; data outputs are don't-care.
//  Handshake:
//   - in_ready = (DEPTH-count >= WAYS), from registered count only. Same-cycle dequeue does not raise it.
//   - enq_n = length of the leading-ones run of in_valid when in_ready && !flush, else 0.
//   - Lanes after the first 0 in in_valid are ignored (e.g. 2'b10 enqueues nothing).
//   - deq_n = min(out_accept, popcount(out_valid)) when !flush, else 0. Excess out_accept is clamped, not an error.
//  Update: count' = count - deq_n + enq_n.
//   - Entries are written at tail..tail+enq_n-1 and removed from head..head+deq_n-1.
//   - Pointers wrap from DEPTH-1 to 0.
//   - Simultaneous enq and deq are legal in any combination.
//  Latency: an entry enqueued in cycle N appears at out_* in cycle N+1 at the earliest. There is no input-to-output combinational path.
//  Outputs: lane i shows entry head+i (mod DEPTH). Fields are registered at enqueue; out_npc may be derived combinationally.
//  Flush: next cycle count=0 and out_valid=0. Inputs and out_accept in the flush cycle are ignored.
//  Decode, stored per entry at enqueue (opc=inst[6:0]):
//   LUI 0110111: opa=zero, opb=U
//   AUIPC 0010111: opa=pc, opb=U
//   JAL 1101111: opa=pc, opb=J, uncond
//   JALR 1100111: opa=rs1, opb=I, uncond
//   BRANCH 1100011: opa=pc, opb=B, cond, no dest
//   LOAD 0000011: opa=rs1, opb=I, rd_mem
//   STORE 0100011: opa=rs1, opb=S, wr_mem, no dest
//   OP-IMM 0010011: opa=rs1, opb=I
//   OP 0110011: opa=rs1, opb=rs2
//   FENCE 0001111: legal, no dest, all other fields 0
//   SYSTEM 1110011: csr_op iff funct3!=0; opb=I; funct3==0 has no dest
//   Any other opc, or inst[1:0]!=2'b11: illegal=1, all other fields 0
//  out_dec bits:
//   [0] illegal  [1] rd_mem  [2] wr_mem  [3] cond_br  [4] uncond_br  [5] csr_op
//   [6] dest_valid: class writes rd and rd!=0
//   [8:7] opa_sel: 0=rs1, 1=pc, 2=zero
//   [11:9] opb_sel: 0=rs2, 1=I, 2=S, 3=B, 4=U, 5=J
// TESTING
//  - Reset, then WAYS=2 enqueue {ADDI x1,x0,5 (0x00500093) @0x100; LW x2,0(x1) (0x0000A103) @0x104} -> next cycle:
//    out_valid=2'b11, count=2; out_dec lane0 = opb I, dest_valid; lane1 = rd_mem, dest_valid; out_npc lane0 = 0x104.
//  - Fill DEPTH=4 with out_accept=0 -> count=4, in_ready=0; further in_valid=2'b11 is dropped; out order unchanged.
//  - count=4, out_accept=1 and in_valid=2'b11 same cycle -> count=3, in_ready=0 that cycle; next cycle in_ready=0 still (needs count<=2).
//  - Wrap: 5 rounds of enq 2 / deq 2 -> PCs emerge strictly in order across the pointer wrap, count stays <=2.
//  - in_valid=2'b10 -> nothing enqueued. out_accept=2 with count=1 -> deq_n=1, count=0.
//  - Inst 0x0000007F (illegal opcode), then flush with count=3 and in_valid=2'b11 -> illegal entry has dec=12'h001; after flush count=0, out_valid=0.
//  - Assert reset mid-burst (count=3) -> outputs clear immediately (asynchronous), in_ready=1.

Source files
------------

// File: rtl/id_decode_queue.sv
// Multi-way RV32I decode stage feeding an in-order circular decode queue.
// Instructions are decoded at enqueue; dispatch drains up to WAYS oldest entries per cycle.
module id_decode_queue #(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [WAYS-1:0]              in_valid,
  input  logic [WAYS*32-1:0]           in_inst,
  input  logic [WAYS*32-1:0]           in_pc,
  output logic                         in_ready,
  output logic [WAYS-1:0]              out_valid,
  output logic [WAYS*32-1:0]           out_inst,
  output logic [WAYS*32-1:0]           out_pc,
  output logic [WAYS*32-1:0]           out_npc,
  output logic [WAYS*12-1:0]           out_dec,
  input  logic [$clog2(WAYS+1)-1:0]    out_accept,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    OPA_RS1  = 2'd0,
    OPA_PC   = 2'd1,
    OPA_ZERO = 2'd2
  } opa_e;

  typedef enum logic [2:0] {
    OPB_RS2 = 3'd0,
    OPB_I   = 3'd1,
    OPB_S   = 3'd2,
    OPB_B   = 3'd3,
    OPB_U   = 3'd4,
    OPB_J   = 3'd5
  } opb_e;

  logic [31:0]   r_inst [DEPTH];
  logic [31:0]   r_pc   [DEPTH];
  logic [11:0]   r_dec  [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [CW-1:0] w_lead;
  logic          w_run;
  logic [CW-1:0] w_enq;
  logic [CW-1:0] w_deq;
  logic [CW-1:0] w_avail;
  logic [CW-1:0] w_acc;
  logic [PW-1:0] w_wr_idx [WAYS];
  logic [PW-1:0] w_rd_idx [WAYS];
  logic [11:0]   w_dec    [WAYS];

  // Pointer advance modulo DEPTH; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] ptr, input int unsigned k);
    int unsigned s;
    s = 32'(ptr) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  function automatic logic [11:0] decode(input logic [31:0] inst);
    opa_e opa;
    opb_e opb;
    logic ill, rdm, wrm, cnd, unc, csr, dst, rdnz;
    opa  = OPA_RS1;
    opb  = OPB_RS2;
    ill  = 1'b0;
    rdm  = 1'b0;
    wrm  = 1'b0;
    cnd  = 1'b0;
    unc  = 1'b0;
    csr  = 1'b0;
    dst  = 1'b0;
    rdnz = (inst[11:7] != 5'd0);
    case (inst[6:0])
      7'b0110111: begin opa = OPA_ZERO; opb = OPB_U; dst = rdnz; end
      7'b0010111: begin opa = OPA_PC;   opb = OPB_U; dst = rdnz; end
      7'b1101111: begin opa = OPA_PC;   opb = OPB_J; unc = 1'b1; dst = rdnz; end
      7'b1100111: begin opa = OPA_RS1;  opb = OPB_I; unc = 1'b1; dst = rdnz; end
      7'b1100011: begin opa = OPA_PC;   opb = OPB_B; cnd = 1'b1; end
      7'b0000011: begin opa = OPA_RS1;  opb = OPB_I; rdm = 1'b1; dst = rdnz; end
      7'b0100011: begin opa = OPA_RS1;  opb = OPB_S; wrm = 1'b1; end
      7'b0010011: begin opa = OPA_RS1;  opb = OPB_I; dst = rdnz; end
      7'b0110011: begin opa = OPA_RS1;  opb = OPB_RS2; dst = rdnz; end
      7'b0001111: begin end
      7'b1110011: begin
        opb = OPB_I;
        csr = (inst[14:12] != 3'd0);
        dst = csr && rdnz;
      end
      default:    ill = 1'b1;
    endcase
    return {opb, opa, dst, csr, unc, cnd, wrm, rdm, ill};
  endfunction

  assign in_ready = (r_count <= CW'(DEPTH - WAYS));
  assign count    = r_count;

  always_comb begin
    w_lead = '0;
    w_run  = 1'b1;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (w_run && in_valid[i]) w_lead = w_lead + CW'(1);
      else                      w_run  = 1'b0;
    end
    w_enq   = (in_ready && !flush) ? w_lead : '0;
    w_avail = (r_count > CW'(WAYS)) ? CW'(WAYS) : r_count;
    w_acc   = CW'(out_accept);
    w_deq   = flush ? '0 : ((w_acc < w_avail) ? w_acc : w_avail);
  end

  always_comb begin
    for (int unsigned i = 0; i < WAYS; i++) begin
      w_wr_idx[i] = wrap_add(r_tail, i);
      w_rd_idx[i] = wrap_add(r_head, i);
      w_dec[i]    = decode(in_inst[32*i +: 32]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= wrap_add(r_head, 32'(w_deq));
      r_tail  <= wrap_add(r_tail, 32'(w_enq));
      r_count <= r_count - w_deq + w_enq;
    end
  end

  // Payload storage carries no reset; validity is tracked solely by r_count.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (CW'(i) < w_enq) begin
        r_inst[w_wr_idx[i]] <= in_inst[32*i +: 32];
        r_pc[w_wr_idx[i]]   <= in_pc[32*i +: 32];
        r_dec[w_wr_idx[i]]  <= w_dec[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < WAYS; i++) begin
      out_valid[i]         = (CW'(i) < r_count);
      out_inst[32*i +: 32] = r_inst[w_rd_idx[i]];
      out_pc[32*i +: 32]   = r_pc[w_rd_idx[i]];
      out_npc[32*i +: 32]  = r_pc[w_rd_idx[i]] + 32'd4;
      out_dec[12*i +: 12]  = r_dec[w_rd_idx[i]];
    end
  end

endmodule

// File: tb/tb_id_decode_queue.sv
// Directed bench for id_decode_queue (WAYS=2, DEPTH=4) with hand-computed expectations.
module tb_id_decode_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic [1:0]  in_valid;
  logic [63:0] in_inst;
  logic [63:0] in_pc;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_inst;
  logic [63:0] out_pc;
  logic [63:0] out_npc;
  logic [23:0] out_dec;
  logic [1:0]  out_accept;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] LW   = 32'h0000A103;
  localparam logic [31:0] ADD  = 32'h002081B3;

  logic [31:0] tinst [10];
  logic [11:0] tdec  [10];

  id_decode_queue #(.WAYS(2), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
    .in_ready(in_ready), .out_valid(out_valid), .out_inst(out_inst),
    .out_pc(out_pc), .out_npc(out_npc), .out_dec(out_dec),
    .out_accept(out_accept), .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                       input logic [31:0] i1, input logic [31:0] p1,
                       input logic [1:0] acc, input logic fl);
    in_valid   = v;
    in_inst    = {i1, i0};
    in_pc      = {p1, p0};
    out_accept = acc;
    flush      = fl;
  endtask

  initial begin
    tinst[0] = 32'h123452B7; tdec[0] = 12'h940;  // LUI x5
    tinst[1] = 32'h0000006F; tdec[1] = 12'hA90;  // JAL x0
    tinst[2] = 32'h00000063; tdec[2] = 12'h688;  // BEQ
    tinst[3] = 32'h0020A023; tdec[3] = 12'h404;  // SW
    tinst[4] = 32'h34011073; tdec[4] = 12'h220;  // CSRRW x0
    tinst[5] = 32'h00000073; tdec[5] = 12'h200;  // ECALL
    tinst[6] = 32'h0000000F; tdec[6] = 12'h000;  // FENCE
    tinst[7] = 32'h00000097; tdec[7] = 12'h8C0;  // AUIPC x1
    tinst[8] = 32'h000100E7; tdec[8] = 12'h250;  // JALR x1
    tinst[9] = 32'h00000000; tdec[9] = 12'h001;  // inst[1:0]!=11

    reset = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 2'd0, 1'b0);
    #3;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    reset = 1'b1;

    drive(2'b11, ADDI, 32'h100, LW, 32'h104, 2'd0, 1'b0);
    tick();
    chk("enq_valid", 32'(out_valid), 32'd3);
    chk("enq_count", 32'(count), 32'd2);
    chk("enq_dec0", 32'(out_dec[11:0]), 32'h240);
    chk("enq_dec1", 32'(out_dec[23:12]), 32'h242);
    chk("enq_npc0", out_npc[31:0], 32'h104);
    chk("enq_inst1", out_inst[63:32], LW);

    drive(2'b11, ADDI, 32'h108, ADD, 32'h10C, 2'd0, 1'b0);
    tick();
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_pc0", out_pc[31:0], 32'h100);
    chk("full_pc1", out_pc[63:32], 32'h104);

    drive(2'b11, ADDI, 32'h200, ADDI, 32'h204, 2'd0, 1'b0);
    tick();
    chk("drop_count", 32'(count), 32'd4);
    chk("drop_pc0", out_pc[31:0], 32'h100);

    drive(2'b11, ADDI, 32'h300, ADDI, 32'h304, 2'd1, 1'b0);
    chk("deq1_ready_pre", 32'(in_ready), 32'd0);
    tick();
    chk("deq1_count", 32'(count), 32'd3);
    chk("deq1_ready", 32'(in_ready), 32'd0);
    chk("deq1_pc0", out_pc[31:0], 32'h104);
    chk("deq1_pc1", out_pc[63:32], 32'h108);

    drive(2'b11, ADDI, 32'h310, ADDI, 32'h314, 2'd0, 1'b0);
    tick();
    chk("hold3_count", 32'(count), 32'd3);
    chk("hold3_ready", 32'(in_ready), 32'd0);

    drive(2'b00, 0, 0, 0, 0, 2'd2, 1'b0);
    tick();
    chk("deq2_count", 32'(count), 32'd1);
    chk("deq2_valid", 32'(out_valid), 32'd1);
    chk("deq2_pc0", out_pc[31:0], 32'h10C);
    chk("deq2_dec0", 32'(out_dec[11:0]), 32'h040);

    drive(2'b10, ADDI, 32'h320, ADDI, 32'h324, 2'd2, 1'b0);
    tick();
    chk("clamp_count", 32'(count), 32'd0);
    chk("clamp_valid", 32'(out_valid), 32'd0);
    chk("clamp_ready", 32'(in_ready), 32'd1);

    for (int k = 0; k < 5; k++) begin
      drive(2'b11, tinst[2*k], 32'hFFFF_FFFC, tinst[2*k+1], 32'h600 + 32'(4*k), 2'd2, 1'b0);
      tick();
      chk("dec_lane0", 32'(out_dec[11:0]), 32'(tdec[2*k]));
      chk("dec_lane1", 32'(out_dec[23:12]), 32'(tdec[2*k+1]));
      chk("dec_npc_wrap", out_npc[31:0], 32'h0);
      chk("dec_pc1", out_pc[63:32], 32'h600 + 32'(4*k));
    end
    drive(2'b00, 0, 0, 0, 0, 2'd2, 1'b0);
    tick();
    chk("dec_drain", 32'(count), 32'd0);

    for (int r = 0; r < 5; r++) begin
      drive(2'b11, ADDI, 32'h400 + 32'(8*r), ADDI, 32'h404 + 32'(8*r), 2'd2, 1'b0);
      tick();
      chk("wrap_pc0", out_pc[31:0], 32'h400 + 32'(8*r));
      chk("wrap_pc1", out_pc[63:32], 32'h404 + 32'(8*r));
      chk("wrap_count", 32'(count), 32'd2);
      chk("wrap_valid", 32'(out_valid), 32'd3);
    end
    drive(2'b00, 0, 0, 0, 0, 2'd2, 1'b0);
    tick();
    chk("wrap_drain", 32'(count), 32'd0);

    drive(2'b11, 32'h0000007F, 32'h500, ADDI, 32'h504, 2'd0, 1'b0);
    tick();
    chk("ill_count", 32'(count), 32'd2);
    chk("ill_dec0", 32'(out_dec[11:0]), 32'h001);
    chk("ill_dec1", 32'(out_dec[23:12]), 32'h240);
    drive(2'b01, ADDI, 32'h508, ADDI, 32'h50C, 2'd0, 1'b0);
    tick();
    chk("pre_flush_count", 32'(count), 32'd3);
    chk("pre_flush_pc0", out_pc[31:0], 32'h500);
    drive(2'b11, ADDI, 32'h510, ADDI, 32'h514, 2'd2, 1'b1);
    tick();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);

    drive(2'b11, ADDI, 32'h700, ADDI, 32'h704, 2'd0, 1'b0);
    tick();
    drive(2'b01, ADDI, 32'h708, ADDI, 32'h70C, 2'd0, 1'b0);
    tick();
    chk("burst_count", 32'(count), 32'd3);
    reset = 1'b0;
    #2;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    drive(2'b00, 0, 0, 0, 0, 2'd0, 1'b0);
    tick();
    reset = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
